ram_port_arbiter: RTL

Sequencer and arbiter for the single byte-wide RAM/IO port. It shares the port between the instruction-fetch requester (i-cache miss path) and the data requester (MEM stage load/store). It serialises each 1/2/4-byte access into per-byte bus cycles and returns assembled words. It sits between those two requesters and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

---
 rtl/ram_port_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the byte-wide RAM/IO port between fetch and data requesters
module ram_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        flush,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_width,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, FETCH, DREAD, DWRITE} state_t;
    state_t state, state_n;
    logic [2:0]  cnt, cnt_n, cnt_inc, width;
    logic [31:0] base, wdata, rbuf, word, addr_n;
    logic [7:0]  dout_n;
    logic        wr_n, if_fin, d_fin, grant, reading;
    assign cnt_inc = cnt + 3'd1;
    assign reading = state == FETCH || state == DREAD;
    assign busy = state != IDLE;
    // merge the byte arriving now into the partially assembled word
    assign word = rbuf | ({24'd0, ram_din} << {cnt - 3'd1, 3'b000});
    // next state and next values of the registered RAM pins
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        addr_n = 32'd0;
        dout_n = 8'd0;
        wr_n = 1'b0;
        if_fin = 1'b0;
        d_fin = 1'b0;
        grant = 1'b0;
        case (state)
            IDLE: if (!if_done && !d_done && (d_req || (if_req && !flush))) begin
                grant = 1'b1;
                cnt_n = 3'd0;
                state_n = d_req ? (d_wr ? DWRITE : DREAD) : FETCH;
                addr_n = d_req ? d_addr : if_addr;
                wr_n = d_req && d_wr;
                dout_n = wr_n ? d_wdata[7:0] : 8'd0;
            end
            FETCH, DREAD: if (state == FETCH && flush) begin
                state_n = IDLE;
                cnt_n = 3'd0;
            end else if (cnt == width) begin
                state_n = IDLE;
                cnt_n = 3'd0;
                if_fin = state == FETCH;
                d_fin = state == DREAD;
            end else begin
                cnt_n = cnt_inc;
                addr_n = cnt_inc < width ? base + {29'd0, cnt_inc} : 32'd0;
            end
            DWRITE: if (cnt_inc == width) begin
                state_n = IDLE;
                cnt_n = 3'd0;
                d_fin = 1'b1;
            end else begin
                cnt_n = cnt_inc;
                addr_n = base + {29'd0, cnt_inc};
                dout_n = wdata[{cnt_inc[1:0], 3'b000} +: 8];
                wr_n = 1'b1;
            end
        endcase
    end
    // state, latched request, read assembly and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 3'd0;
            width <= 3'd0;
            base <= 32'd0;
            wdata <= 32'd0;
            rbuf <= 32'd0;
            ram_addr <= 32'd0;
            ram_dout <= 8'd0;
            ram_wr <= 1'b0;
            if_done <= 1'b0;
            d_done <= 1'b0;
            if_data <= 32'd0;
            d_rdata <= 32'd0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            ram_addr <= addr_n;
            ram_dout <= dout_n;
            ram_wr <= wr_n;
            if_done <= if_fin;
            d_done <= d_fin;
            if (grant) begin
                width <= d_req ? d_width : 3'd4;
                base <= d_req ? d_addr : if_addr;
                wdata <= d_wdata;
                rbuf <= 32'd0;
            end else if (reading && cnt != 3'd0) rbuf <= word;
            if (if_fin) if_data <= word;
            if (d_fin && state == DREAD) d_rdata <= word;
        end
    end
endmodule
